// File: rtl/transpose_ctrl.sv
// transpose_ctrl: fill/drain sequencer for the 32x32 transpose buffer sitting
// between the row and column 1-D DCT stages. Handles one block at a time:
// rows are accepted until the block is full, then columns are handed out
// until it is empty. The data path lives in the buffer; this block only
// produces the load/unload strobes and the handshake signals.
module transpose_ctrl #(
  parameter int N  = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_size,
  output logic          load,
  output logic          unload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [1:0]    out_size,
  output logic [CW-1:0] row_idx,
  output logic [CW-1:0] col_idx,
  output logic          block_done
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] last_idx;
  logic          row_last;
  logic          col_last;

  // Index of the final row/column for the latched TU size (n - 1, n = 4 << size).
  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    last_idx = CW'(N - 1);
    case (out_size)
      2'd0:    last_idx = CW'(3);
      2'd1:    last_idx = CW'(7);
      2'd2:    last_idx = CW'(15);
      default: last_idx = CW'(N - 1);
    endcase
  end

  assign row_last = (row_idx == last_idx);
  assign col_last = (col_idx == last_idx);

  // State register; reset parks the controller in INIT.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) state <= INIT;
    else      state <= state_nx;
  end

  // Next-state logic: flush overrides everything and returns to FILL.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = FILL;
    end else begin
      case (state)
        INIT:    state_nx = FILL;
        FILL:    if (load && row_last)   state_nx = DRAIN;
        DRAIN:   if (unload && col_last) state_nx = FILL;
        default: state_nx = INIT;
      endcase
    end
  end

  // Output logic: handshakes and strobes, all gated by flush.
  always_comb begin
    in_ready   = (state == FILL)  && !flush;
    out_valid  = (state == DRAIN) && !flush;
    load       = in_valid  && in_ready;
    unload     = out_valid && out_ready;
    out_last   = col_last  && out_valid;
    block_done = unload    && col_last;
  end

  // Row/column counters and the size latched on the first row of a block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx  <= '0;
      col_idx  <= '0;
      out_size <= 2'd0;
    end else if (flush) begin
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      if (load) begin
        // The size only changes at a block boundary; later rows ignore in_size.
        if (row_idx == '0) out_size <= in_size;
        row_idx <= row_last ? '0 : row_idx + CW'(1);
      end
      if (unload) begin
        col_idx <= col_last ? '0 : col_idx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_transpose_ctrl.sv
// Directed testbench for transpose_ctrl, with a small behavioural transpose
// buffer so column contents can be checked against hand-computed values.
module tb_transpose_ctrl;

  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_size;
  logic          load;
  logic          unload;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [1:0]    out_size;
  logic [CW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          block_done;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural buffer: rows shift in at y0, columns shift out toward column 0.
  int row_in [4];
  int bufm   [32][4];

  transpose_ctrl #(.N(32), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_size    (in_size),
    .load       (load),
    .unload     (unload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_size   (out_size),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 31; i > 0; i--) bufm[i] <= bufm[i-1];
      for (int j = 0; j < 4; j++) bufm[0][j] <= row_in[j];
    end
    if (unload) begin
      for (int i = 0; i < 32; i++) begin
        for (int j = 0; j < 3; j++) bufm[i][j] <= bufm[i][j+1];
        bufm[i][3] <= 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   0);
    check({tag, "_load"},       32'(load),       0);
    check({tag, "_unload"},     32'(unload),     0);
    check({tag, "_out_valid"},  32'(out_valid),  0);
    check({tag, "_out_last"},   32'(out_last),   0);
    check({tag, "_block_done"}, 32'(block_done), 0);
    check({tag, "_out_size"},   32'(out_size),   0);
    check({tag, "_row_idx"},    32'(row_idx),    0);
    check({tag, "_col_idx"},    32'(col_idx),    0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r);
    for (int j = 0; j < 4; j++) row_in[j] = r * 4 + j + 1;
  endtask

  initial begin
    bit exp_fill;
    int exp_row, exp_col, nload, nunl;
    bit done;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_size = 2'd3; out_ready = 1'b1;
    set_row(0);

    // ---- reset: all outputs low even with handshakes asserted
    tick(); tick();
    #1 check_all_zero("reset");
    rst = 1'b1;
    #1 check("init_idle_in_ready", 32'(in_ready), 0);
    tick();

    // ---- 32x32 back-to-back: 32 loads, 32 unloads, 64 cycles
    for (int c = 0; c < 64; c++) begin
      #1;
      check($sformatf("t1_load_%0d", c),   32'(load),       32'(c < 32));
      check($sformatf("t1_unload_%0d", c), 32'(unload),     32'(c >= 32));
      check($sformatf("t1_last_%0d", c),   32'(out_last),   32'(c == 63));
      check($sformatf("t1_done_%0d", c),   32'(block_done), 32'(c == 63));
      if (c < 32) check($sformatf("t1_row_%0d", c), 32'(row_idx), 32'(c));
      else        check($sformatf("t1_col_%0d", c), 32'(col_idx), 32'(c - 32));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; in_size = 2'd0;
    #1;
    check("t1_end_in_ready",  32'(in_ready),  1);
    check("t1_end_out_valid", 32'(out_valid), 0);

    // ---- 4x4 block with data through the buffer model
    for (int r = 0; r < 4; r++) begin
      set_row(r); in_valid = 1'b1;
      #1;
      check($sformatf("t2_load_%0d", r), 32'(load),    1);
      check($sformatf("t2_row_%0d", r),  32'(row_idx), 32'(r));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_valid_%0d", k), 32'(out_valid), 1);
      check($sformatf("t2_col_%0d", k),   32'(col_idx),   32'(k));
      check($sformatf("t2_size_%0d", k),  32'(out_size),  0);
      check($sformatf("t2_last_%0d", k),  32'(out_last),  32'(k == 3));
      for (int i = 0; i < 4; i++)
        check($sformatf("t2_y%0d_col%0d", i, k), 32'(bufm[i][0]), 32'((3 - i) * 4 + k + 1));
      tick();
    end
    out_ready = 1'b0;
    #1 check("t2_end_in_ready", 32'(in_ready), 1);

    // ---- 16x16 with in_size changed mid-block: size stays latched at 2
    for (int r = 0; r < 16; r++) begin
      in_size = (r < 3) ? 2'd2 : 2'd0; in_valid = 1'b1;
      #1;
      check($sformatf("t3_load_%0d", r), 32'(load),    1);
      check($sformatf("t3_row_%0d", r),  32'(row_idx), 32'(r));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("t3_col_%0d", k),  32'(col_idx),    32'(k));
      check($sformatf("t3_size_%0d", k), 32'(out_size),   2);
      check($sformatf("t3_last_%0d", k), 32'(out_last),   32'(k == 15));
      check($sformatf("t3_done_%0d", k), 32'(block_done), 32'(k == 15));
      tick();
    end
    out_ready = 1'b0;

    // ---- 8x8 with random throttling on both sides
    in_size = 2'd1;
    exp_fill = 1'b1; exp_row = 0; exp_col = 0; nload = 0; nunl = 0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("t4_load",   32'(load),       32'(exp_fill && in_valid));
      check("t4_unload", 32'(unload),     32'(!exp_fill && out_ready));
      check("t4_excl",   32'(load && unload), 0);
      check("t4_row",    32'(row_idx),    32'(exp_row));
      check("t4_col",    32'(col_idx),    32'(exp_col));
      check("t4_done",   32'(block_done), 32'(!exp_fill && out_ready && exp_col == 7));
      if (load)   nload++;
      if (unload) nunl++;
      if (exp_fill && in_valid) begin
        if (exp_row == 7) begin exp_row = 0; exp_fill = 1'b0; end
        else exp_row++;
      end else if (!exp_fill && out_ready) begin
        if (exp_col == 7) begin exp_col = 0; exp_fill = 1'b1; done = 1'b1; end
        else exp_col++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_finished", 32'(done),  1);
    check("t4_nload",    32'(nload), 8);
    check("t4_nunload",  32'(nunl),  8);

    // ---- flush on row 10 of a 32x32 block, then a clean 4x4 block
    in_size = 2'd3; in_valid = 1'b1;
    for (int r = 0; r < 10; r++) begin
      #1 check($sformatf("t5_load_%0d", r), 32'(load), 1);
      tick();
    end
    flush = 1'b1;
    #1;
    check("t5_flush_load",     32'(load),     0);
    check("t5_flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("t5_post_row_idx",  32'(row_idx),  0);
    check("t5_post_in_ready", 32'(in_ready), 1);
    in_size = 2'd0;
    for (int r = 0; r < 4; r++) begin
      set_row(r); in_valid = 1'b1;
      #1;
      check($sformatf("t5_load4_%0d", r), 32'(load),    1);
      check($sformatf("t5_row4_%0d", r),  32'(row_idx), 32'(r));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t5_col_%0d", k),  32'(col_idx),    32'(k));
      check($sformatf("t5_size_%0d", k), 32'(out_size),   0);
      check($sformatf("t5_y0_%0d", k),   32'(bufm[0][0]), 32'(13 + k));
      check($sformatf("t5_done_%0d", k), 32'(block_done), 32'(k == 3));
      tick();
    end
    out_ready = 1'b0;

    // ---- asynchronous reset in DRAIN at col_idx 5
    in_size = 2'd1; in_valid = 1'b1;
    for (int r = 0; r < 8; r++) tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("t6_col5",   32'(col_idx),   5);
    check("t6_valid",  32'(out_valid), 1);
    in_valid = 1'b1;
    rst = 1'b0;
    #1 check_all_zero("t6_async");
    tick();
    rst = 1'b1;
    #1 check("t6_idle_in_ready", 32'(in_ready), 0);
    tick();
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_row_idx",  32'(row_idx),  0);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transpose_ctrl.md
# transpose_ctrl

Sequencer for the 32×32 transpose buffer that sits between the row (first) and column (second) 1-D DCT stages. It accepts row vectors from the row stage over a valid/ready handshake and issues one `load` strobe per accepted row. Once a whole block is in the buffer, it issues one `unload` strobe per column accepted by the column stage, again over valid/ready. It supports HEVC TU sizes 4/8/16/32 and handles exactly one block at a time: it fills, then drains, then fills the next block.

## Interface
Parameters:
- `N`, default 32: buffer dimension. Fixed at 32; size codes map to n = 4 << size.
- `CW`, default 5: width of the row and column counters (log2 N).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort. Discards the current block and returns to FILL with count 0.
- `in_valid`  in  1  row stage presents a row.
- `in_ready`  out  1  controller accepts a row this cycle.
- `in_size`  in  2  TU size code (0:4, 1:8, 2:16, 3:32). Sampled only on the first row of a block.
- `load`  out  1  to buffer `load`; high for exactly one cycle per accepted row.
- `unload`  out  1  to buffer `unload`; high for exactly one cycle per accepted column.
- `out_valid`  out  1  buffer column 0 holds a valid column.
- `out_ready`  in  1  column stage accepts the column.
- `out_last`  out  1  the presented column is the final column of the block.
- `out_size`  out  2  latched size code of the block being drained.
- `row_idx`  out  CW  rows accepted so far in the current block.
- `col_idx`  out  CW  index of the column currently presented.
- `block_done`  out  1  one-cycle pulse on acceptance of the last column.

## Operation
- State machine with three states:
  - INIT: entered only via reset. Leaves to FILL on the first clock edge after `rst` is released.
  - FILL: `in_ready`=1 and `out_valid`=0.
  - DRAIN: `in_ready`=0 and `out_valid`=1.
- Row handshake: `load` = `in_valid` & `in_ready` & ~`flush` (combinational). `in_ready` = (state==FILL) & ~`flush`.
- Column handshake: `unload` = `out_valid` & `out_ready` & ~`flush` (combinational). `out_valid` = (state==DRAIN) & ~`flush`.
- `load` and `unload` are never high in the same cycle.
- FILL:
  - On the first accepted row (`row_idx`==0), latch `in_size` into `out_size`; n = 4 << `out_size`. `in_size` is ignored on later rows.
  - Each accepted row increments `row_idx`.
  - On acceptance with `row_idx`==n-1, clear `row_idx` and go to DRAIN.
- DRAIN:
  - Each accepted column increments `col_idx`.
  - `out_last` = (`col_idx`==n-1) & `out_valid`.
  - On acceptance with `col_idx`==n-1, pulse `block_done`, clear `col_idx` and go to FILL.
- Buffer data placement is a property of the buffer, not of this block. For n<32, row r of the block appears at buffer output y[n-1-r]. The column stage reads y0..y(n-1) and reverses the order. This block does not touch data.
- Stalls:
  - `in_valid` low in FILL, or `out_ready` low in DRAIN, holds state, counters and all strobes at 0.
  - No timeout.
- `flush`:
  - Forces FILL with `row_idx`=`col_idx`=0 on the next edge and suppresses `load`/`unload` in the same cycle.
  - `flush` takes priority over everything.
  - Buffer contents are left stale. They are overwritten by the next fill.
- Reset (`rst` low, asynchronous):
  - State goes to INIT.
  - All outputs are 0: `in_ready`, `load`, `unload`, `out_valid`, `out_last`, `block_done`, `out_size`, `row_idx`, `col_idx`.
  - Reset mid-fill or mid-drain abandons the block.

## Timing
- `in_ready` rises in the first cycle after the first edge following `rst` release.
- Last row accepted at edge k → `out_valid`=1 in the cycle after edge k. The first column is available with zero extra latency, because the buffer updates on the same edge.
- Last column accepted at edge m → `in_ready`=1 in the cycle after edge m; `block_done` is high in the cycle before edge m.
- Best-case throughput is one block per 2n cycles; the 32×32 block takes 64 cycles.
- `col_idx`, `row_idx`, `out_size` and the state are registered. `load`, `unload`, `out_last` and `block_done` are combinational from registered state and handshake inputs.

## Test plan
- Reset release, `in_valid`=1, `in_size`=3, `out_ready`=1:
  - 32 `load` pulses on consecutive cycles, then `out_valid` the next cycle.
  - 32 `unload` pulses, with `out_last` on `col_idx`=31.
  - `block_done` once.
  - 64 cycles total.
- `in_size`=0 (4×4), with rows carrying values 1..16 into a behavioural buffer model:
  - 4 loads, then 4 columns.
  - Column 0 on y0..y3 = 13, 9, 5, 1.
  - `out_size`=0.
- `in_size`=2 latched on the first row, then `in_size` changed to 0 on row 3:
  - The block still takes 16 rows and 16 columns; `out_size` stays 2.
- Random `in_valid`/`out_ready` throttling at 50% for an 8×8 block:
  - Exactly 8 loads and 8 unloads.
  - `load` and `unload` are never simultaneous.
  - Counters hold during stalls.
- `flush` on row 10 of a 32×32 block, then a new 4×4 block:
  - No `load` in the flush cycle; `row_idx`=0 the next cycle.
  - The 4×4 block completes normally.
- `rst` low during DRAIN at `col_idx`=5:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, one idle cycle, then `in_ready`=1 and `row_idx`=0.
